mant_align_seq: RTL
===================

# mant_align_seq

Mantissa alignment unit for the floating-point adder datapath, placed directly after the exponent add/sub stage. It consumes that stage's sign/magnitude exponent difference, and when the sign is set it undoes the stage's "magnitude one less" encoding. It then swaps the operands so the larger exponent comes first and right-shifts the smaller mantissa, producing guard, round and sticky bits. Operands and results move through valid/ready handshakes, so the block accepts one operand pair per transaction.

## Interface
- MAN_W, 11, mantissa width including hidden bit
- EXP_W, 5, exponent width; difference input is EXP_W+1 bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept; high only in IDLE
- sign12  input  1  1 = expa < expb, and diff is |expa-expb|-1 (one's-complement form)
- diff  input  EXP_W+1  exponent difference magnitude from exponent stage
- expa, expb  input  EXP_W  operand exponents
- mana, manb  input  MAN_W  operand mantissas
- out_valid  output  1  aligned result present
- out_ready  input  1  downstream accepts result
- swapped  output  1  1 = operand b was the larger-exponent operand
- exp_out  output  EXP_W  larger exponent
- big_man  output  MAN_W  unshifted mantissa of the larger-exponent operand
- sml_man  output  MAN_W  aligned mantissa of the smaller-exponent operand
- grs  output  3  {guard, round, sticky}

## Operation
- Reset values: in_ready=1 after the first post-reset edge; out_valid=0; swapped=0; exp_out=0; big_man=0; sml_man=0; grs=0; state=IDLE.
- Shift amount: amt = sign12 ? diff+1 : diff, computed at EXP_W+1 bits. For any legal input, diff+1 cannot overflow.
- Swap on accept: when sign12=1, big=manb, sml=mana, exp_out=expb, swapped=1. Otherwise big=mana, sml=manb, exp_out=expa, swapped=0.
- Saturation: count = min(amt, MAN_W+3). After MAN_W+3 shifts, sml_man=0, guard=0, round=0, and sticky = OR of the original sml.
- One-bit shift step applied to {sml, g, r, s}:
  - sml >>= 1
  - g ← sml[0]
  - r ← g
  - s ← s | r
- FSM:
  - IDLE: when in_valid && in_ready, load the operands, clear grs and set count. Go to DONE if count=0, else go to SHIFT.
  - SHIFT: perform one step per cycle and decrement count. Go to DONE after the step that reaches count=0.
  - DONE: out_valid=1, with all outputs held stable. On out_ready, return to IDLE.
- Within the handshake, simultaneous in_valid and out_ready in DONE do not accept new input; the next accept can occur no earlier than the following cycle.
- rst asserted in any state aborts the transaction in flight: state goes to IDLE and every output returns to its reset value on that edge.

## Timing
- Accept at edge N.
- Serial build: out_valid rises at edge N+1+count. For count=0, that is edge N+1.
- Worst case: out_valid at edge N+1+MAN_W+3 (N+15 with defaults).
- Throughput: one transaction per count+2 cycles when out_ready is held high.
- out_valid deasserts on the edge after the out_ready handshake. in_ready is high in the same cycle it deasserts.

## Configuration
- ALIGN_FAST_EN defined: SHIFT performs the full saturated shift in one cycle (barrel shift with a sticky OR-reduce). out_valid rises at N+2 for count>0 and at N+1 for count=0. Results must be bit-identical to the serial build.
- ALIGN_FAST_EN undefined: serial one-bit-per-cycle shifting, with latencies as given above.

## Structure
- Shared package fp_align_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the localparam SAT_SHIFT = MAN_W+3
  - the grs bit-index constants
- One sub-module, grs_shift_step: a combinational one-bit {sml, g, r, s} shift with sticky accumulation. It is instantiated in the serial path and reused as the reference for the fast-path equivalence check.

## Test plan
- **Serial shift, no swap:** sign12=0, diff=3, expa=10, expb=7, mana=0x400, manb=0x405 → swapped=0, exp_out=10, big_man=0x400, sml_man=0x080, grs=3'b101. out_valid at N+4.
- **One's-complement correction with swap:** sign12=1, diff=2, expa=4, expb=7, mana=0x405, manb=0x7FF → amt=3, swapped=1, exp_out=7, big_man=0x7FF, sml_man=0x080, grs=3'b101.
- **Saturation:** sign12=0, diff=20, manb=0x001 → sml_man=0, grs=3'b001, out_valid at N+15. Repeat with manb=0 → grs=3'b000.
- **Zero shift:** sign12=0, diff=0 → no SHIFT state; out_valid at N+1, sml_man=manb, grs=0.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout. Release out_ready → IDLE next cycle, and a second transaction is accepted correctly.
- **Reset mid-shift:** assert rst during the 2nd SHIFT cycle of a diff=10 transaction → all outputs 0 and in_ready=1. A following diff=1 transaction completes correctly. Run the whole plan with and without ALIGN_FAST_EN.

Source files
------------

// File: rtl/fp_align_pkg.sv
// Shared definitions for the mantissa alignment unit: FSM state encodings,
// the saturating shift limit and the {guard, round, sticky} bit positions.
package fp_align_pkg;

   localparam int MAN_W_DFLT = 11;
   localparam int EXP_W_DFLT = 5;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam int GRS_G = 2;
   localparam int GRS_R = 1;
   localparam int GRS_S = 0;

   // Beyond this many steps every mantissa bit has already landed in sticky.
   function automatic int sat_shift(input int man_w);
      return man_w + 3;
   endfunction

   localparam int SAT_SHIFT = sat_shift(MAN_W_DFLT);

endpackage

// File: rtl/mant_align_seq_grs_shift_step.sv
// One-bit right shift of {sml, g, r, s}; the bit leaving round is folded into sticky.
module grs_shift_step
   import fp_align_pkg::*;
#(
   parameter int MAN_W = MAN_W_DFLT
) (
   input  logic [MAN_W-1:0] sml_in,
   input  logic [2:0]       grs_in,
   output logic [MAN_W-1:0] sml_out,
   output logic [2:0]       grs_out
);

   assign sml_out        = sml_in >> 1;
   assign grs_out[GRS_G] = sml_in[0];
   assign grs_out[GRS_R] = grs_in[GRS_G];
   assign grs_out[GRS_S] = grs_in[GRS_S] | grs_in[GRS_R];

endmodule

// File: rtl/mant_align_seq.sv
// Operand swap and mantissa alignment with guard/round/sticky generation.
// Define ALIGN_FAST_EN to do the whole saturated shift in a single SHIFT cycle.
module mant_align_seq
   import fp_align_pkg::*;
#(
   parameter int MAN_W = MAN_W_DFLT,
   parameter int EXP_W = EXP_W_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sign12,
   input  logic [EXP_W:0]   diff,
   input  logic [EXP_W-1:0] expa,
   input  logic [EXP_W-1:0] expb,
   input  logic [MAN_W-1:0] mana,
   input  logic [MAN_W-1:0] manb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             swapped,
   output logic [EXP_W-1:0] exp_out,
   output logic [MAN_W-1:0] big_man,
   output logic [MAN_W-1:0] sml_man,
   output logic [2:0]       grs
);

   localparam int CW = EXP_W + 1;
   localparam logic [CW-1:0] SAT = CW'(sat_shift(MAN_W));

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [CW-1:0]    amt;
   logic [CW-1:0]    amt_sat;
   logic [MAN_W-1:0] step_sml;
   logic [2:0]       step_grs;

   // A set sign12 means diff carries |expa-expb|-1, so add the one back.
   assign amt     = sign12 ? diff + CW'(1) : diff;
   assign amt_sat = (amt > SAT) ? SAT : amt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

`ifdef ALIGN_FAST_EN
   logic [MAN_W+1:0] wide;
   logic [MAN_W+1:0] wide_sh;
   logic [MAN_W+1:0] lost_mask;

   // {sml, g, r} is one wide field; whatever falls off its low end is sticky.
   always_comb begin
      wide      = {sml_man, 2'b00};
      wide_sh   = wide >> count;
      lost_mask = ~({(MAN_W+2){1'b1}} << count);
      step_sml  = wide_sh[MAN_W+1:2];
      step_grs  = {wide_sh[1], wide_sh[0], (|(wide & lost_mask)) | grs[GRS_S]};
   end
`else
   grs_shift_step #(.MAN_W(MAN_W)) u_step (
      .sml_in  (sml_man),
      .grs_in  (grs),
      .sml_out (step_sml),
      .grs_out (step_grs)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         swapped <= 1'b0;
         exp_out <= '0;
         big_man <= '0;
         sml_man <= '0;
         grs     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  swapped <= sign12;
                  exp_out <= sign12 ? expb : expa;
                  big_man <= sign12 ? manb : mana;
                  sml_man <= sign12 ? mana : manb;
                  grs     <= '0;
                  count   <= amt_sat;
                  state   <= (amt_sat == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               sml_man <= step_sml;
               grs     <= step_grs;
`ifdef ALIGN_FAST_EN
               count   <= '0;
               state   <= DONE;
`else
               count   <= count - CW'(1);
               if (count == CW'(1))
                  state <= DONE;
`endif
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
